// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer; define UART_TX_PARITY_EN to add an even-parity symbol
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int SET = CLOCK_FREQ / BAUD_RATE;
    localparam int TW  = SET > 1 ? $clog2(SET) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
    logic            parity;
`endif
    logic            push;
    logic            pop;
    logic            tick;

    assign data_in_ready = !rst && fifo_count < CW'(FIFO_DEPTH);
    assign push = data_in_valid && data_in_ready;
    assign tick = timer == TW'(SET - 1);
    assign pop  = fifo_count != '0 && (state == IDLE || (state == STOP && tick));

    // storage array, no reset needed since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // queue pointers and occupancy; a push and a pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // frame sequencer; a pop always starts a new frame, so STOP chains straight into START
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            timer <= (state == IDLE || tick) ? '0 : timer + TW'(1);
            if (pop) begin
                shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity     <= ^mem[rd_ptr];
`endif
                serial_out <= 1'b0;
                busy       <= 1'b1;
                state      <= START;
            end else begin
                case (state)
                    START: if (tick) begin
                        state      <= DATA;
                        serial_out <= shift[0];
                        bit_idx    <= '0;
                    end
                    DATA: if (tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            shift      <= shift >> 1;
                            serial_out <= shift[1];
                        end
                    end
                    PARITY: if (tick) begin
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end
                    STOP: if (tick) begin
                        state      <= IDLE;
                        serial_out <= 1'b1;
                        busy       <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus random traffic against a queue-and-timeline model of the transmitter
module tb_uart_tx_fifo;
    localparam int SPB   = 5;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif
    localparam int FLEN = NSYM * SPB;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx_fifo #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE (10_000_000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc = 0;
    int busy_cyc = 0;
    int low_cyc = 0;

    // model: pending bytes plus the byte on the line and how many cycles it has been on the line
    logic [7:0] q[$];
    bit         active = 1'b0;
    int         elapsed = 0;
    logic [7:0] cur = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic sym(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NSYM == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        bit ending;
        bit do_pop;
        bit do_push;
        if (r) begin
            q.delete();
            active = 1'b0;
            elapsed = 0;
        end else begin
            ending  = active && elapsed == FLEN - 1;
            do_pop  = q.size() > 0 && (!active || ending);
            do_push = v && q.size() < DEPTH;
            if (active) elapsed++;
            if (ending) active = 1'b0;
            if (do_pop) begin
                cur = q.pop_front();
                active = 1'b1;
                elapsed = 0;
            end
            if (do_push) q.push_back(d);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        data_in_valid = v;
        data_in = d;
        rst = r;
        #1;
        check("ready", data_in_ready, !r && q.size() < DEPTH);
        if (data_in_valid && data_in_ready) acc++;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        check("line", serial_out, active ? sym(cur, elapsed / SPB) : 1'b1);
        check("busy", busy, active);
        check("count", fifo_count, q.size());
        if (busy) busy_cyc++;
        if (!serial_out) low_cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        int guard;
        int mode;
        data_in_valid = 1'b0;
        data_in = 8'h00;
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("reset_line", serial_out, 1'b1);
        check("reset_count", fifo_count, 0);

        // single byte frames; second exercises odd parity data when enabled
        busy_cyc = 0;
        step(1'b1, 8'h41, 1'b0);
        idle(FLEN + 20);
        check("t1_busy_len", busy_cyc, FLEN);
        busy_cyc = 0;
        step(1'b1, 8'h07, 1'b0);
        idle(FLEN + 20);
        check("t6_busy_len", busy_cyc, FLEN);

        // hold valid high for ten bytes
        step(1'b0, 8'h00, 1'b1);
        acc = 0;
        busy_cyc = 0;
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        check("t2_acc9", acc, 9);
        check("t2_full_ready", data_in_ready, 1'b0);
        guard = 0;
        while (acc < 10 && guard < 200) begin
            step(1'b1, 8'h19, 1'b0);
            guard++;
        end
        check("t2_acc10", acc, 10);
        check("t2_wait", guard, FLEN - 6);
        idle(10 * FLEN);
        check("t2_contig", busy_cyc, 10 * FLEN);

        // reset during data bit 3 with four bytes queued
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        check("t3_queued", fifo_count, 4);
        idle(18);
        step(1'b0, 8'h00, 1'b1);
        check("t3_line", serial_out, 1'b1);
        check("t3_count", fifo_count, 0);
        check("t3_busy", busy, 1'b0);
        idle(200);

        // push on the edge a STOP ends with one byte queued
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        idle(FLEN - 1);
        step(1'b1, 8'h81, 1'b0);
        check("t4_count", fifo_count, 1);
        check("t4_start", serial_out, 1'b0);
        idle(2 * FLEN + 20);

        // quiet line after reset
        step(1'b0, 8'h00, 1'b1);
        busy_cyc = 0;
        low_cyc = 0;
        idle(1000);
        check("t5_busy", busy_cyc, 0);
        check("t5_low", low_cyc, 0);

        // random traffic with varying offered load and rare resets
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) mode = int'($urandom_range(1, 4));
            step($urandom_range(0, 3) < mode, 8'($urandom), $urandom_range(0, 499) == 0);
        end
        idle(DEPTH * FLEN + FLEN);
        check("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
